div_unit: RTL and testbench

Iterative radix-2 integer divider for the execute stage of the RV64 pipeline. It implements DIV/DIVU/REM/REMU and their W variants and pairs with the single-cycle ALU as the multi-cycle arithmetic path. Execute stalls on `in_ready`/`out_valid`. Results follow RISC-V M-extension semantics, including divide-by-zero and signed-overflow cases.

---
 rtl/div_unit_pkg.sv | 47 ++++
 rtl/div_unit_if.sv | 29 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the execute-stage divider: the 64-bit word type and the
// divider opcode/state enums, iteration counts and a W-result helper.
package common;
  typedef logic [63:0] u64;
endpackage

package pipes;
  import common::*;

  // Bit 2 selects the W form, bit 1 selects remainder, bit 0 selects unsigned.
  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
  } divop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_ITER64 = 64;
  localparam int unsigned DIV_ITER32 = 32;

  function automatic logic op_is_w(input divop_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input divop_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input divop_t op);
    return ~op[0];
  endfunction

  // W results are always sign-extended from bit 31, even for unsigned W ops.
  function automatic u64 w_extend(input logic is_w, input u64 v);
    return is_w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// Execute <-> divider handshake bundle.
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high and flush is low; in_ready is high only while the
// unit is idle. out_valid is a one-cycle pulse and c stays stable until the
// next result is written. flush aborts any in-flight operation.
interface div_unit_if;
  import common::*;
  import pipes::*;

  logic       flush;
  logic       in_valid;
  logic       in_ready;
  u64         a;
  u64         b;
  divop_t     op;
  logic       out_valid;
  u64         c;
  div_state_t dbg_state;

  modport master (
    output flush, in_valid, a, b, op,
    input  in_ready, out_valid, c, dbg_state
  );

  modport slave (
    input  flush, in_valid, a, b, op,
    output in_ready, out_valid, c, dbg_state
  );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift {rem, quo} left by one, then subtract
// the divisor from the partial remainder if it fits.
module div_step
  import common::*;
(
  input  logic [64:0] i_rem,
  input  u64          i_quo,
  input  u64          i_divisor,
  output logic [64:0] o_rem,
  output u64          o_quo
);
  // One extra bit so the shifted remainder never overflows before compare.
  logic [65:0] w_rem_sh;

  assign w_rem_sh = {i_rem, i_quo[63]};

  // Trial subtract; keep the difference and set the quotient bit when it fits.
  always_comb begin
    o_quo = {i_quo[62:0], 1'b0};
    o_rem = w_rem_sh[64:0];
    if (w_rem_sh >= {2'b00, i_divisor}) begin
      o_rem    = 65'(w_rem_sh - {2'b00, i_divisor});
      o_quo[0] = 1'b1;
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and the W
// forms. Divide-by-zero and signed overflow resolve at accept; everything
// else runs 64 (or 32 for W) single-bit steps on operand magnitudes, with
// the sign fix-up and W extension applied on the way into DONE.
module div_unit
  import common::*;
  import pipes::*;
(
  input  logic      clk,
  input  logic      reset,
  div_unit_if.slave io
);
  div_state_t  r_state;
  logic [64:0] r_rem;
  u64          r_quo;
  u64          r_div;
  logic [6:0]  r_cnt;
  u64          r_c;
  logic        r_is_w;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_accept;
  logic        w_is_w;
  logic        w_is_rem;
  logic        w_signed;
  u64          w_a_ext;
  u64          w_b_ext;
  logic        w_sa;
  logic        w_sb;
  u64          w_a_abs;
  u64          w_b_abs;
  logic        w_div_zero;
  logic        w_ovf;
  u64          w_min;
  u64          w_special_c;
  logic [64:0] w_nrem;
  u64          w_nquo;
  u64          w_q_fix;
  u64          w_r_fix;
  u64          w_final_c;

  assign w_accept = io.in_valid & (r_state == IDLE) & ~io.flush;
  assign w_is_w   = op_is_w(io.op);
  assign w_is_rem = op_is_rem(io.op);
  assign w_signed = op_is_signed(io.op);

  // Operand extension, magnitudes and special-case detection at accept.
  always_comb begin
    w_a_ext = io.a;
    w_b_ext = io.b;
    if (w_is_w) begin
      w_a_ext = w_signed ? {{32{io.a[31]}}, io.a[31:0]} : {32'b0, io.a[31:0]};
      w_b_ext = w_signed ? {{32{io.b[31]}}, io.b[31:0]} : {32'b0, io.b[31:0]};
    end
    w_sa       = w_signed & w_a_ext[63];
    w_sb       = w_signed & w_b_ext[63];
    w_a_abs    = w_sa ? (~w_a_ext + 64'd1) : w_a_ext;
    w_b_abs    = w_sb ? (~w_b_ext + 64'd1) : w_b_ext;
    w_div_zero = (w_b_ext == 64'd0);
    w_min      = w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    w_ovf      = w_signed & (w_a_ext == w_min) & (w_b_ext == {64{1'b1}});
    if (w_div_zero) begin
      w_special_c = w_extend(w_is_w, w_is_rem ? w_a_ext : {64{1'b1}});
    end else begin
      w_special_c = w_extend(w_is_w, w_is_rem ? 64'd0 : w_a_ext);
    end
  end

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_nrem),
    .o_quo     (w_nquo)
  );

  // Sign fix-up and W extension of the result produced by the final step.
  always_comb begin
    w_q_fix   = r_neg_q ? (~w_nquo + 64'd1) : w_nquo;
    w_r_fix   = r_neg_r ? (~w_nrem[63:0] + 64'd1) : w_nrem[63:0];
    w_final_c = w_extend(r_is_w, r_is_rem ? w_r_fix : w_q_fix);
  end

  // Control FSM plus the datapath registers it sequences.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_c      <= '0;
      r_is_w   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (io.flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_w   <= w_is_w;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            if (w_div_zero || w_ovf) begin
              r_c     <= w_special_c;
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_rem   <= '0;
              // W dividends sit in the top half so 32 shifts bring the
              // quotient down into bits [31:0].
              r_quo   <= w_is_w ? {w_a_abs[31:0], 32'b0} : w_a_abs;
              r_div   <= w_b_abs;
              r_cnt   <= w_is_w ? 7'(DIV_ITER32) : 7'(DIV_ITER64);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_rem <= w_nrem;
          r_quo <= w_nquo;
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_c     <= w_final_c;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = (r_state == IDLE);
  assign io.out_valid = (r_state == DONE);
  assign io.c         = r_c;
  assign io.dbg_state = r_state;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: result values, result latency,
// special cases, W ops, flush and mid-operation reset.
module tb_div_unit;
  import common::*;
  import pipes::*;

  logic clk = 1'b0;
  logic reset;

  div_unit_if io ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  u64 exp_q[$];
  u64 last_c = 64'd0;

  task automatic check(input string tag, input u64 got, input u64 exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Presents one op (called just after a rising edge), then checks the
  // latency to out_valid, the result and the return of in_ready.
  task automatic do_op(input string tag, input divop_t op, input u64 a, input u64 b,
                       input u64 exp_c, input int exp_lat);
    int lat;
    u64 exp;
    exp_q.push_back(exp_c);
    io.op       = op;
    io.a        = a;
    io.b        = b;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a        = {$urandom, $urandom};
    io.b        = {$urandom, $urandom};
    io.op       = divop_t'(3'($urandom_range(0, 7)));
    check({tag, "_busy_rdy"}, u64'(io.in_ready), 64'd0);
    lat = 1;
    while (!io.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, u64'(lat), u64'(exp_lat));
    exp = exp_q.pop_front();
    check({tag, "_c"}, io.c, exp);
    last_c = exp;
    @(posedge clk);
    #1;
    check({tag, "_rdy_after"}, u64'(io.in_ready), 64'd1);
    check({tag, "_ov_after"}, u64'(io.out_valid), 64'd0);
  endtask

  initial begin
    int seen_ov;
    reset       = 1'b1;
    io.flush    = 1'b0;
    io.in_valid = 1'b0;
    io.a        = '0;
    io.b        = '0;
    io.op       = DIV;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_c", io.c, 64'd0);
    check("rst_rdy", u64'(io.in_ready), 64'd1);
    check("rst_ov", u64'(io.out_valid), 64'd0);
    check("rst_state", u64'(io.dbg_state), u64'(IDLE));

    do_op("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 65);
    do_op("div_m7_2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem_m7_2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("rem_7_m2", REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    do_op("divu_5_0", DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("remu_5_0", REMU, 64'd5, 64'd0, 64'd5, 1);
    do_op("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    do_op("divuw", DIVUW, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    do_op("divw_ovf", DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1);
    do_op("remw_m7_2", REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("remuw_zero", REMUW, 64'hAAAA_AAAA_8000_0001, 64'hFFFF_FFFF_0000_0000,
          64'hFFFF_FFFF_8000_0001, 1);

    // flush together with in_valid while idle: nothing accepted
    io.flush    = 1'b1;
    io.in_valid = 1'b1;
    io.op       = DIVU;
    io.a        = 64'd8;
    io.b        = 64'd2;
    @(posedge clk);
    #1;
    io.flush    = 1'b0;
    io.in_valid = 1'b0;
    check("flush_idle_rdy", u64'(io.in_ready), 64'd1);
    check("flush_idle_state", u64'(io.dbg_state), u64'(IDLE));

    // DIVU accepted at T, flush during T+10, new op accepted at T+11
    io.op       = DIVU;
    io.a        = 64'd1000;
    io.b        = 64'd3;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    seen_ov = 0;
    for (int i = 1; i < 10; i++) begin
      if (io.out_valid) seen_ov++;
      @(posedge clk);
      #1;
    end
    check("flush_busy_state", u64'(io.dbg_state), u64'(BUSY));
    io.flush = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    if (io.out_valid) seen_ov++;
    check("flush_no_ov", u64'(seen_ov), 64'd0);
    check("flush_rdy", u64'(io.in_ready), 64'd1);
    check("flush_c_kept", io.c, last_c);
    do_op("after_flush_9_3", DIVU, 64'd9, 64'd3, 64'd3, 65);

    // reset in the middle of an operation
    io.op       = DIVU;
    io.a        = 64'd50;
    io.b        = 64'd5;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_c", io.c, 64'd0);
    check("midrst_rdy", u64'(io.in_ready), 64'd1);
    check("midrst_ov", u64'(io.out_valid), 64'd0);
    do_op("after_rst_50_5", DIVU, 64'd50, 64'd5, 64'd10, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
